// File: rtl/rr_grant_ctrl_pkg.sv
// rr_ctrl_pkg: shared FSM state type and default sizing for the round-robin grant controller
package rr_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, GAP} rr_state_t;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_MAX_HOLD = 8;
endpackage

// File: rtl/rr_grant_ctrl_pick.sv
// rr_pick: round-robin selector, first requester at or after ptr (rotate, LSB-first pick, rotate back)
module rr_pick
    import rr_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         pick,
    output logic [$clog2(NUM_REQ)-1:0] index,
    output logic                       valid
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] rot, oh;
    logic [IW-1:0] lsb;
    assign valid = en && |req;
    assign oh = rot & (~rot + 1'b1);
    assign index = ptr + lsb;
    // NUM_REQ is a power of two, so truncating the index to IW bits is the modulo wrap
    always_comb begin
        rot = '0;
        pick = '0;
        lsb = '0;
        for (int i = 0; i < NUM_REQ; i++) rot[i] = req[IW'(i + int'(ptr))];
        for (int i = NUM_REQ - 1; i >= 0; i--) lsb = rot[i] ? IW'(i) : lsb;
        for (int i = 0; i < NUM_REQ; i++) pick[i] = valid & oh[IW'(i - int'(ptr))];
    end
endmodule

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: multi-cycle round-robin grant of one shared resource with hold limit and turnaround gap
module rr_grant_ctrl
    import rr_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       preempt,
    output logic [$clog2(NUM_REQ)-1:0] ptr
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    rr_state_t state;
    logic [HW-1:0] hold_cnt;
    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0] pick_idx;
    logic pick_valid, release_now;
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req(req), .ptr(ptr), .en(en), .pick(pick), .index(pick_idx), .valid(pick_valid)
    );
    assign busy = |gnt;
    assign release_now = !req[owner] || hold_cnt == HW'(MAX_HOLD - 1);
    // a release with the owner still requesting can only be the hold limit, hence preempt
    always_ff @(posedge clock) begin
        preempt <= 1'b0;
        if (reset) begin
            state <= IDLE;
            gnt <= '0;
            owner <= '0;
            ptr <= '0;
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_valid) begin
                state <= GRANT;
                gnt <= pick;
                owner <= pick_idx;
                hold_cnt <= '0;
            end
        end else if (state == GRANT) begin
            if (release_now) begin
                state <= GAP;
                gnt <= '0;
                ptr <= owner + 1'b1;
                preempt <= req[owner];
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl: vector table and sequence checks of rr_grant_ctrl through an expected-result queue
module tb_rr_grant_ctrl;
    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] ptr;
        logic       pre;
        logic [1:0] own;
    } vec_t;

    logic clock = 1'b0;
    logic reset, en, busy, preempt;
    logic [3:0] req, gnt;
    logic [1:0] owner, ptr;
    int n_vec = 0;
    int n_bad = 0;
    vec_t exp_q[$];
    vec_t tbl_a[$];
    vec_t tbl_b[$];

    always #5 clock = ~clock;

    rr_grant_ctrl #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
        .clock(clock), .reset(reset), .en(en), .req(req), .gnt(gnt),
        .owner(owner), .busy(busy), .preempt(preempt), .ptr(ptr)
    );

    function automatic vec_t mk(logic r, logic e, logic [3:0] q, logic [3:0] g,
                                logic [1:0] p, logic pr, logic [1:0] o);
        vec_t v;
        v.rst = r; v.en = e; v.req = q; v.gnt = g; v.ptr = p; v.pre = pr; v.own = o;
        return v;
    endfunction

    // drive one cycle of inputs, queue the outputs expected after the next edge, check them #1 later
    task automatic apply(input string tag, input vec_t v);
        vec_t x;
        reset = v.rst;
        en = v.en;
        req = v.req;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        x = exp_q.pop_front();
        n_vec++;
        if (gnt !== x.gnt || ptr !== x.ptr || preempt !== x.pre || owner !== x.own || busy !== (|x.gnt)) begin
            n_bad++;
            $display("FAIL %s vec %0d: got gnt=%b ptr=%0d preempt=%b owner=%0d busy=%b, want gnt=%b ptr=%0d preempt=%b owner=%0d busy=%b",
                     tag, n_vec, gnt, ptr, preempt, owner, busy, x.gnt, x.ptr, x.pre, x.own, |x.gnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d vectors", n_vec);
        $fatal(1);
    end

    initial begin
        tbl_a.push_back(mk(1, 1, 4'b1111, 4'b0000, 0, 0, 0));
        tbl_a.push_back(mk(1, 1, 4'b1111, 4'b0000, 0, 0, 0));
        tbl_a.push_back(mk(0, 1, 4'b1111, 4'b0001, 0, 0, 0));
        // fairness skip: reach ptr=2, then only 0 and 1 request
        tbl_b.push_back(mk(0, 1, 4'b0010, 4'b0010, 3, 0, 1));
        tbl_b.push_back(mk(0, 1, 4'b0000, 4'b0000, 2, 0, 1));
        tbl_b.push_back(mk(0, 1, 4'b0000, 4'b0000, 2, 0, 1));
        tbl_b.push_back(mk(0, 1, 4'b0011, 4'b0001, 2, 0, 0));
        tbl_b.push_back(mk(0, 1, 4'b0010, 4'b0000, 1, 0, 0));
        tbl_b.push_back(mk(0, 1, 4'b0000, 4'b0000, 1, 0, 0));
        tbl_b.push_back(mk(0, 1, 4'b0000, 4'b0000, 1, 0, 0));
        // en gating
        tbl_b.push_back(mk(0, 0, 4'b1000, 4'b0000, 1, 0, 0));
        tbl_b.push_back(mk(0, 0, 4'b1000, 4'b0000, 1, 0, 0));
        tbl_b.push_back(mk(0, 0, 4'b1000, 4'b0000, 1, 0, 0));
        tbl_b.push_back(mk(0, 1, 4'b1000, 4'b1000, 1, 0, 3));
        tbl_b.push_back(mk(0, 0, 4'b1000, 4'b1000, 1, 0, 3));
        tbl_b.push_back(mk(0, 0, 4'b1000, 4'b1000, 1, 0, 3));
        tbl_b.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 3));
        tbl_b.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 3));
        tbl_b.push_back(mk(0, 0, 4'b1111, 4'b0000, 0, 0, 3));
        // reset mid-grant with gnt=0010, ptr=1
        tbl_b.push_back(mk(0, 1, 4'b0001, 4'b0001, 0, 0, 0));
        tbl_b.push_back(mk(0, 1, 4'b0000, 4'b0000, 1, 0, 0));
        tbl_b.push_back(mk(0, 1, 4'b0000, 4'b0000, 1, 0, 0));
        tbl_b.push_back(mk(0, 1, 4'b0010, 4'b0010, 1, 0, 1));
        tbl_b.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 0, 0));
        tbl_b.push_back(mk(0, 1, 4'b0010, 4'b0010, 0, 0, 1));

        foreach (tbl_a[i]) apply("reset", tbl_a[i]);

        for (int o = 0; o < 4; o++) begin
            apply("rotate_hold", mk(0, 1, 4'b1111, 4'(1 << o), 2'(o), 0, 2'(o)));
            apply("rotate_hold", mk(0, 1, 4'b1111, 4'(1 << o), 2'(o), 0, 2'(o)));
            apply("rotate_drop", mk(0, 1, 4'b1111 & ~4'(1 << o), 4'b0000, 2'(o + 1), 0, 2'(o)));
            apply("rotate_gap", mk(0, 1, 4'b1111, 4'b0000, 2'(o + 1), 0, 2'(o)));
            apply("rotate_next", mk(0, 1, 4'b1111, 4'(1 << ((o + 1) % 4)), 2'(o + 1), 0, 2'(o + 1)));
        end
        apply("rotate_end", mk(0, 1, 4'b0000, 4'b0000, 1, 0, 0));
        apply("rotate_end", mk(0, 1, 4'b0000, 4'b0000, 1, 0, 0));
        apply("rotate_end", mk(0, 1, 4'b0000, 4'b0000, 1, 0, 0));

        for (int c = 0; c < 20; c++)
            apply("timeout", mk(0, 1, 4'b0100, (c % 10 < 8) ? 4'b0100 : 4'b0000,
                                (c < 8) ? 2'd1 : 2'd3, c % 10 == 8, 2'd2));

        foreach (tbl_b[i]) apply("table", tbl_b[i]);

        // reset on the very edge that would force a release: no preempt, no ptr update
        for (int c = 0; c < 7; c++) apply("reset_at_limit", mk(0, 1, 4'b0010, 4'b0010, 0, 0, 1));
        apply("reset_at_limit", mk(1, 1, 4'b0010, 4'b0000, 0, 0, 0));
        apply("reset_at_limit", mk(0, 1, 4'b0000, 4'b0000, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
